// File: rtl/p_sa_sync_filt_bank.sv
// p_sa_sync_filt_bank: bank of STAGES-deep level synchronisers with debounce filter and edge pulses (optional SA_SYNC_TEST_BYPASS_EN adds TEST_MODE bypass)
module p_sa_sync_filt_bank #(
  parameter int WIDTH = 1,
  parameter int STAGES = 3,
  parameter int DEB_CYC = 0,
  parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
  input  logic             DST_CLK,
  input  logic             DST_CLR,
`ifdef SA_SYNC_TEST_BYPASS_EN
  input  logic             TEST_MODE,
`endif
  input  logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] RISE,
  output logic [WIDTH-1:0] FALL,
  output logic             ANY_CHG
);
  localparam int CW = (DEB_CYC > 0) ? $clog2(DEB_CYC + 1) : 1;
  if (STAGES < 2 || STAGES > 4) begin : g_bad_stages
    $error("p_sa_sync_filt_bank: STAGES must be 2..4");
  end
  (* async_reg = "true" *) logic [STAGES-1:0][WIDTH-1:0] sync_q;
  logic [STAGES-1:0][WIDTH-1:0] sync_d;
  logic [WIDTH-1:0][CW-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d, rise_q, rise_d, fall_q, fall_d, syn, upd;
  logic any_q, any_d;
  // pure shift chain, then per-channel debounce and pulse generation
  always_comb begin
    sync_d = {sync_q[STAGES-2:0], D};
    syn = sync_q[STAGES-1];
    upd = '0;
    cnt_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      upd[i] = (syn[i] != q_q[i]) && (cnt_q[i] == CW'(DEB_CYC));
      cnt_d[i] = (syn[i] == q_q[i] || upd[i]) ? '0 : cnt_q[i] + CW'(1);
    end
    q_d = (q_q & ~upd) | (syn & upd);
    rise_d = upd & syn;
    fall_d = upd & ~syn;
    any_d = |(rise_d | fall_d);
`ifdef SA_SYNC_TEST_BYPASS_EN
    if (TEST_MODE) begin
      q_d = D;
      cnt_d = '0;
      rise_d = '0;
      fall_d = '0;
      any_d = 1'b0;
    end
`endif
  end
  // all state cleared asynchronously so in-flight transitions are dropped
  always_ff @(posedge DST_CLK or posedge DST_CLR) begin
    if (DST_CLR) begin
      sync_q <= {STAGES{RST_VAL}};
      cnt_q <= '0;
      q_q <= RST_VAL;
      rise_q <= '0;
      fall_q <= '0;
      any_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      q_q <= q_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
      any_q <= any_d;
    end
  end
  assign Q = q_q;
  assign RISE = rise_q;
  assign FALL = fall_q;
  assign ANY_CHG = any_q;
endmodule

// File: tb/tb_p_sa_sync_filt_bank.sv
// tb_p_sa_sync_filt_bank: scoreboard bench for the synchroniser/debounce bank
module tb_p_sa_sync_filt_bank;
  localparam int W = 4, ST = 3, DB = 2;
  localparam logic [W-1:0] RV = '0;
  logic clk = 1'b0, clr = 1'b1, test_mode = 1'b0;
  logic [W-1:0] d = '0, q, rise, fall;
  logic any;
  int n_run = 0, n_fail = 0;
  typedef struct packed {logic [W-1:0] q, r, f; logic a;} exp_t;
  exp_t sb[$];
  logic [W-1:0] hist[$];
  logic [W-1:0] mq = RV;
  p_sa_sync_filt_bank #(.WIDTH(W), .STAGES(ST), .DEB_CYC(DB), .RST_VAL(RV)) dut (
    .DST_CLK(clk),
    .DST_CLR(clr),
`ifdef SA_SYNC_TEST_BYPASS_EN
    .TEST_MODE(test_mode),
`endif
    .D(d),
    .Q(q),
    .RISE(rise),
    .FALL(fall),
    .ANY_CHG(any)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  // drive one input value, predict the next edge from the sampled-D history, compare after it
  task automatic cyc(input logic [W-1:0] v);
    exp_t e;
    int n, k;
    logic [W-1:0] upd, b;
    d = v;
    hist.push_back(v);
    n = hist.size();
    upd = '1;
    for (int j = 0; j <= DB; j++) begin
      k = n - ST - j - 1;
      b = (k >= 0) ? hist[k] : RV;
      upd &= b ^ mq;
    end
    e.r = upd & ~mq;
    e.f = upd & mq;
    e.a = |upd;
    mq ^= upd;
    e.q = mq;
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk("q", q, e.q);
    chk("rise", rise, e.r);
    chk("fall", fall, e.f);
    chk("any", any, e.a);
  endtask
  task automatic hold(input logic [W-1:0] v, input int nc);
    for (int i = 0; i < nc; i++) cyc(v);
  endtask
  task automatic do_reset(input int nc);
    clr = 1'b1;
    #1;
    chk("rst_q", q, RV);
    chk("rst_rise", rise, 0);
    chk("rst_fall", fall, 0);
    chk("rst_any", any, 0);
    for (int i = 0; i < nc; i++) @(negedge clk);
    chk("rst_hold_q", q, RV);
    clr = 1'b0;
    hist.delete();
    sb.delete();
    mq = RV;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    @(negedge clk);
    do_reset(2);
    hold(4'b0001, 8);
    hold(4'b0011, 2);
    hold(4'b0001, 8);
    hold(4'b0011, 3);
    hold(4'b0001, 10);
    hold(4'b1010, 8);
    hold(4'b0101, 8);
    for (int i = 0; i < 30; i++) hold(W'($urandom), $urandom_range(1, 5));
    hold(4'b0000, 8);
    hold(4'b0100, 3);
    do_reset(2);
    hold(4'b0100, 10);
    hold(4'b1111, 8);
    do_reset(1);
    hold(4'b0000, 6);
`ifdef SA_SYNC_TEST_BYPASS_EN
    test_mode = 1'b1;
    d = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    chk("byp_q", q, 4'b1111);
    chk("byp_rise", rise, 0);
    chk("byp_any", any, 0);
    d = 4'b0000;
    @(posedge clk);
    @(negedge clk);
    chk("byp_q0", q, 4'b0000);
    chk("byp_fall", fall, 0);
    test_mode = 1'b0;
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
